pulse_delay_bank: RTL and testbench

Multi-channel programmable pulse delay: each of `CHANNELS` independent channels detects a rising edge on its trigger input, waits a runtime-programmable number of `clk` cycles, then emits a fixed-length output pulse. It generalises the single-channel fixed-delay strobe generator with the following additions:
- per-trigger programmable delay;
- configurable pulse length;
- busy and drop status;
- optional retrigger.

It sits between slow-interface strobe decoders and the sequencing logic that needs delayed, aligned strobes.

---
 rtl/pulse_delay_bank.sv | 109 ++++++++++
 tb/tb_pulse_delay_bank.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_delay_bank.sv
// Multi-channel pulse delay: each channel turns a rising trigger edge into a PULSE_LEN-cycle pulse
// after a delay latched at acceptance. Define PULSE_DELAY_RETRIGGER_EN to let busy channels reload.
module pulse_delay_bank #(
  parameter int CHANNELS  = 4,
  parameter int W         = 8,
  parameter int PULSE_LEN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in_data,
  input  logic [W-1:0]        delay,
  output logic [CHANNELS-1:0] out_data,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] dropped
);

  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {IDLE, COUNT, PULSE} state_t;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t        state_reg, state_next;
      logic [W-1:0]  cnt_reg, cnt_next;
      logic [PW-1:0] pcnt_reg, pcnt_next;
      logic          prev_reg;
      logic          out_reg, busy_reg, drop_reg, drop_next;
      logic          trig, accept;

      assign trig = in_data[gi] & ~prev_reg;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pcnt_next  = pcnt_reg;
        drop_next  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
          IDLE: accept = trig;
          COUNT: begin
            if (cnt_reg == '0) begin
              state_next = PULSE;
              pcnt_next  = '0;
            end else begin
              cnt_next = cnt_reg - W'(1);
            end
`ifdef PULSE_DELAY_RETRIGGER_EN
            accept = trig;
`else
            drop_next = trig;
`endif
          end
          PULSE: begin
            if (pcnt_reg == PCNT_LAST) begin
              // Final pulse edge: a new trigger is taken with no gap.
              state_next = IDLE;
              accept     = trig;
            end else begin
              pcnt_next = pcnt_reg + PW'(1);
`ifdef PULSE_DELAY_RETRIGGER_EN
              accept = trig;
`else
              drop_next = trig;
`endif
            end
          end
          default: state_next = IDLE;
        endcase
        // Acceptance overrides whatever the running state would have done.
        if (accept) begin
          if (delay == '0) begin
            state_next = PULSE;
            pcnt_next  = '0;
          end else begin
            state_next = COUNT;
            cnt_next   = delay - W'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          pcnt_reg  <= '0;
          prev_reg  <= 1'b1;
          out_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          drop_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          pcnt_reg  <= pcnt_next;
          prev_reg  <= in_data[gi];
          out_reg   <= (state_next == PULSE);
          busy_reg  <= (state_next != IDLE);
          drop_reg  <= drop_next;
        end
      end

      assign out_data[gi] = out_reg;
      assign busy[gi]     = busy_reg;
      assign dropped[gi]  = drop_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pulse_delay_bank.sv
// Scoreboard bench for pulse_delay_bank: expected per-cycle outputs are queued when a trigger
// is driven and popped one per clock as the DUT responds.
module tb_pulse_delay_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] delay;
  logic [3:0] in_a, out_a, busy_a, drop_a;
  logic [3:0] in_b, out_b, busy_b, drop_b;

  typedef struct {
    logic [3:0] out;
    logic [3:0] busy;
    logic [3:0] drop;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pulse_delay_bank #(.CHANNELS(4), .W(8), .PULSE_LEN(1)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_a), .delay(delay),
    .out_data(out_a), .busy(busy_a), .dropped(drop_a)
  );

  pulse_delay_bank #(.CHANNELS(4), .W(8), .PULSE_LEN(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(in_b), .delay(delay),
    .out_data(out_b), .busy(busy_b), .dropped(drop_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({out_a, busy_a, drop_a} !== 12'h000) begin
      failures++;
      $display("FAIL reset_a out/busy/drop=%b/%b/%b expected 0000/0000/0000", out_a, busy_a, drop_a);
    end
    checks++;
    if ({out_b, busy_b, drop_b} !== 12'h000) begin
      failures++;
      $display("FAIL reset_b out/busy/drop=%b/%b/%b expected 0000/0000/0000", out_b, busy_b, drop_b);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({out_a, busy_a, drop_a} !== 12'h000) begin
      failures++;
      $display("FAIL reset_release out/busy/drop=%b/%b/%b expected 0000/0000/0000", out_a, busy_a, drop_a);
    end
  endtask

  task automatic test_basic_delay();
    exp_t e;
    delay = 8'd5;
    in_a  = 4'b0001;
    for (int j = 0; j < 10; j++) begin
      e.out  = {3'b000, 1'(j == 5)};
      e.busy = {3'b000, 1'(j <= 5)};
      e.drop = 4'b0000;
      sbq.push_back(e);
    end
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 0) in_a = 4'b0000;
      e = sbq.pop_front();
      checks++;
      if ({out_a, busy_a, drop_a} !== {e.out, e.busy, e.drop}) begin
        failures++;
        $display("FAIL basic_delay j=%0d out/busy/drop=%b/%b/%b expected %b/%b/%b",
                 j, out_a, busy_a, drop_a, e.out, e.busy, e.drop);
      end
    end
    $display("basic_delay: delay=5 ch0 done");
  endtask

  task automatic test_zero_long();
    exp_t e;
    delay = 8'd0;
    in_b  = 4'b0001;
    for (int j = 0; j < 6; j++) begin
      e.out  = {3'b000, 1'(j <= 2)};
      e.busy = {3'b000, 1'(j <= 2)};
      e.drop = 4'b0000;
      sbq.push_back(e);
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j == 0) in_b = 4'b0000;
      e = sbq.pop_front();
      checks++;
      if ({out_b, busy_b, drop_b} !== {e.out, e.busy, e.drop}) begin
        failures++;
        $display("FAIL zero_delay j=%0d out/busy/drop=%b/%b/%b expected %b/%b/%b",
                 j, out_b, busy_b, drop_b, e.out, e.busy, e.drop);
      end
    end
    $display("zero_delay: delay=0 pulse_len=3 done");
    delay = 8'd255;
    in_b  = 4'b0001;
    for (int j = 0; j < 261; j++) begin
      e.out  = {3'b000, 1'(j >= 255 && j <= 257)};
      e.busy = {3'b000, 1'(j <= 257)};
      e.drop = 4'b0000;
      sbq.push_back(e);
    end
    for (int j = 0; j < 261; j++) begin
      tick();
      if (j == 0) in_b = 4'b0000;
      e = sbq.pop_front();
      checks++;
      if ({out_b, busy_b, drop_b} !== {e.out, e.busy, e.drop}) begin
        failures++;
        $display("FAIL max_delay j=%0d out/busy/drop=%b/%b/%b expected %b/%b/%b",
                 j, out_b, busy_b, drop_b, e.out, e.busy, e.drop);
      end
    end
    $display("max_delay: delay=255 pulse_len=3 done");
  endtask

  task automatic test_busy_trigger();
    exp_t e;
    delay = 8'd10;
    in_a  = 4'b0001;
    for (int j = 0; j < 17; j++) begin
`ifdef PULSE_DELAY_RETRIGGER_EN
      e.out  = {3'b000, 1'(j == 14)};
      e.busy = {3'b000, 1'(j <= 14)};
      e.drop = 4'b0000;
`else
      e.out  = {3'b000, 1'(j == 10)};
      e.busy = {3'b000, 1'(j <= 10)};
      e.drop = {3'b000, 1'(j == 4)};
`endif
      sbq.push_back(e);
    end
    for (int j = 0; j < 17; j++) begin
      tick();
      e = sbq.pop_front();
      checks++;
      if ({out_a, busy_a, drop_a} !== {e.out, e.busy, e.drop}) begin
        failures++;
        $display("FAIL busy_trigger j=%0d out/busy/drop=%b/%b/%b expected %b/%b/%b",
                 j, out_a, busy_a, drop_a, e.out, e.busy, e.drop);
      end
      if (j == 0) in_a = 4'b0000;
      if (j == 3) in_a = 4'b0001;
      if (j == 4) in_a = 4'b0000;
    end
    $display("busy_trigger: second edge at k+4 done");
  endtask

  task automatic test_final_edge();
    exp_t e;
    delay = 8'd10;
    in_a  = 4'b0001;
    for (int j = 0; j < 16; j++) begin
      e.out  = {3'b000, 1'(j == 10 || j == 13)};
      e.busy = {3'b000, 1'(j <= 13)};
      e.drop = 4'b0000;
      sbq.push_back(e);
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      e = sbq.pop_front();
      checks++;
      if ({out_a, busy_a, drop_a} !== {e.out, e.busy, e.drop}) begin
        failures++;
        $display("FAIL final_edge j=%0d out/busy/drop=%b/%b/%b expected %b/%b/%b",
                 j, out_a, busy_a, drop_a, e.out, e.busy, e.drop);
      end
      if (j == 0) in_a = 4'b0000;
      if (j == 10) begin
        in_a  = 4'b0001;
        delay = 8'd2;
      end
      if (j == 11) in_a = 4'b0000;
    end
    $display("final_edge: back-to-back accept done");
  endtask

  task automatic test_simultaneous();
    exp_t e;
    delay = 8'd3;
    in_a  = 4'b1010;
    for (int j = 0; j < 7; j++) begin
      e.out  = (j == 3) ? 4'b1010 : 4'b0000;
      e.busy = (j <= 3) ? 4'b1010 : 4'b0000;
      e.drop = 4'b0000;
      sbq.push_back(e);
    end
    for (int j = 0; j < 7; j++) begin
      tick();
      if (j == 0) begin
        in_a  = 4'b0000;
        delay = 8'd9;
      end
      e = sbq.pop_front();
      checks++;
      if ({out_a, busy_a, drop_a} !== {e.out, e.busy, e.drop}) begin
        failures++;
        $display("FAIL simultaneous j=%0d out/busy/drop=%b/%b/%b expected %b/%b/%b",
                 j, out_a, busy_a, drop_a, e.out, e.busy, e.drop);
      end
    end
    $display("simultaneous: ch1+ch3 delay=3 done");
  endtask

  task automatic test_reset_abort();
    exp_t e;
    delay = 8'd20;
    in_a  = 4'b0100;
    for (int j = 0; j < 3; j++) begin
      e.out  = 4'b0000;
      e.busy = 4'b0100;
      e.drop = 4'b0000;
      sbq.push_back(e);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      if (j == 0) in_a = 4'b0000;
      e = sbq.pop_front();
      checks++;
      if ({out_a, busy_a, drop_a} !== {e.out, e.busy, e.drop}) begin
        failures++;
        $display("FAIL abort_pre j=%0d out/busy/drop=%b/%b/%b expected %b/%b/%b",
                 j, out_a, busy_a, drop_a, e.out, e.busy, e.drop);
      end
    end
    #2;
    reset = 1'b1;
    in_a  = 4'b0001;
    #1;
    checks++;
    if ({out_a, busy_a, drop_a} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset out/busy/drop=%b/%b/%b expected 0000/0000/0000", out_a, busy_a, drop_a);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int j = 0; j < 30; j++) begin
      e.out  = 4'b0000;
      e.busy = 4'b0000;
      e.drop = 4'b0000;
      sbq.push_back(e);
    end
    for (int j = 0; j < 30; j++) begin
      tick();
      e = sbq.pop_front();
      checks++;
      if ({out_a, busy_a, drop_a} !== {e.out, e.busy, e.drop}) begin
        failures++;
        $display("FAIL abort_post j=%0d out/busy/drop=%b/%b/%b expected %b/%b/%b",
                 j, out_a, busy_a, drop_a, e.out, e.busy, e.drop);
      end
    end
    in_a = 4'b0000;
    $display("reset_abort: mid-count reset, held-high input done");
  endtask

  initial begin
    reset = 1'b1;
    delay = 8'd0;
    in_a  = 4'b0000;
    in_b  = 4'b0000;
    test_reset();
    test_basic_delay();
    tick();
    test_zero_long();
    tick();
    test_busy_trigger();
    tick();
    test_final_edge();
    tick();
    test_simultaneous();
    tick();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
